// File: rtl/norm_arbiter.sv
// Two-requester round-robin arbiter feeding a shared mantissa normalizer.
// S1 holds the granted request; S2 holds the normalized result until taken.
module norm_arbiter #(
    parameter int SIZE_DATA = 24,
    parameter int SIZE_LOPD = 5,
    parameter int SIZE_EXP  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid0,
    input  logic                 i_valid1,
    output logic                 o_ready0,
    output logic                 o_ready1,
    input  logic [SIZE_DATA-1:0] i_data0,
    input  logic [SIZE_DATA-1:0] i_data1,
    input  logic [SIZE_EXP-1:0]  i_exp0,
    input  logic [SIZE_EXP-1:0]  i_exp1,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_DATA-1:0] o_data,
    output logic [SIZE_EXP-1:0]  o_exp,
    output logic                 o_src,
    output logic                 o_zero,
    output logic                 o_underflow
);
    // Common width wide enough to compare shift distance against exponent.
    localparam int CW = (SIZE_EXP > SIZE_LOPD) ? SIZE_EXP + 1 : SIZE_LOPD + 1;

    logic                 s1_valid;
    logic [SIZE_DATA-1:0] s1_data;
    logic [SIZE_EXP-1:0]  s1_exp;
    logic                 s1_src;
    logic                 last_grant;

    logic adv2, s1_free, grant0, grant1, accept, pick;

    always_comb begin
        adv2    = ~o_valid | i_ready;
        s1_free = ~s1_valid | adv2;
        grant0  = i_valid0 & (~i_valid1 | last_grant);
        grant1  = i_valid1 & (~i_valid0 | ~last_grant);
    end

    assign o_ready0 = grant0 & s1_free & ~i_rst;
    assign o_ready1 = grant1 & s1_free & ~i_rst;
    assign accept   = o_ready0 | o_ready1;
    assign pick     = o_ready1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_exp     <= '0;
            s1_src     <= 1'b0;
            last_grant <= 1'b1;
        end else if (s1_free) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data    <= pick ? i_data1 : i_data0;
                s1_exp     <= pick ? i_exp1 : i_exp0;
                s1_src     <= pick;
                last_grant <= pick;
            end
        end
    end

    logic [SIZE_LOPD-1:0] pos, shift, amt;
    logic [CW-1:0]        shift_w, exp_w;
    logic                 zero, uf;
    logic [SIZE_DATA-1:0] nrm_data;
    logic [SIZE_EXP-1:0]  nrm_exp;

    // Leading-one detector: last hit from LSB upward is the highest set bit.
    always_comb begin
        pos = '0;
        for (int i = 0; i < SIZE_DATA; i++)
            if (s1_data[i]) pos = SIZE_LOPD'(i);
    end

    always_comb begin
        zero    = ~|s1_data;
        shift   = SIZE_LOPD'(SIZE_DATA - 1) - pos;
        shift_w = CW'(shift);
        exp_w   = CW'(s1_exp);
        uf      = shift_w > exp_w;
        // On underflow exp < shift, so it fits the shifter's amount width.
        amt      = uf ? SIZE_LOPD'(s1_exp) : shift;
        nrm_data = s1_data << amt;
        nrm_exp  = uf ? '0 : SIZE_EXP'(exp_w - shift_w);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid     <= 1'b0;
            o_data      <= '0;
            o_exp       <= '0;
            o_src       <= 1'b0;
            o_zero      <= 1'b0;
            o_underflow <= 1'b0;
        end else if (adv2) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_data      <= zero ? '0 : nrm_data;
                o_exp       <= zero ? '0 : nrm_exp;
                o_src       <= s1_src;
                o_zero      <= zero;
                o_underflow <= ~zero & uf;
            end
        end
    end
endmodule

// File: tb/tb_norm_arbiter.sv
// Scoreboard bench: accepted requests push a reference result, S2 output pops it.
module tb_norm_arbiter;
    logic        i_clk = 1'b0, i_rst = 1'b1;
    logic        i_valid0 = 1'b0, i_valid1 = 1'b0, i_ready = 1'b1;
    logic [23:0] i_data0 = '0, i_data1 = '0;
    logic [7:0]  i_exp0 = '0, i_exp1 = '0;
    logic        o_ready0, o_ready1, o_valid, o_src, o_zero, o_underflow;
    logic [23:0] o_data;
    logic [7:0]  o_exp;

    norm_arbiter #(.SIZE_DATA(24), .SIZE_LOPD(5), .SIZE_EXP(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_valid0(i_valid0), .i_valid1(i_valid1),
        .o_ready0(o_ready0), .o_ready1(o_ready1),
        .i_data0(i_data0), .i_data1(i_data1),
        .i_exp0(i_exp0), .i_exp1(i_exp1),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_data(o_data), .o_exp(o_exp), .o_src(o_src),
        .o_zero(o_zero), .o_underflow(o_underflow)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic [23:0] data;
        logic [7:0]  exp;
        logic        src, zero, uf;
    } res_t;

    res_t sb[$];
    int   checks = 0, errors = 0;
    bit   m_s1 = 0, m_s2 = 0, lg = 1;
    int   gen0 = 0, gen1 = 0;
    bit   rnd_ready = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h @%0t", tag, got, want, $time);
        end
    endtask

    // Reference: shift one bit at a time, spending exponent until normalized or exhausted.
    function automatic res_t ref_norm(input logic [23:0] d, input logic [7:0] e, input logic s);
        res_t r;
        logic [23:0] m;
        int ee;
        r = '0;
        r.src = s;
        if (d == 0) begin
            r.zero = 1'b1;
        end else begin
            m  = d;
            ee = e;
            while (!m[23] && ee > 0) begin
                m  = m << 1;
                ee = ee - 1;
            end
            r.data = m;
            r.uf   = !m[23];
            r.exp  = 8'(ee);
        end
        return r;
    endfunction

    // Cycle model of handshake and occupancy, evaluated with inputs settled.
    always @(negedge i_clk) begin
        bit adv2, free, g0, g1, a0, a1, n_s2;
        res_t r;
        if (i_rst) begin
            chk("rst_rdy0", o_ready0, 0);
            chk("rst_rdy1", o_ready1, 0);
            m_s1 = 0; m_s2 = 0; lg = 1;
            sb.delete();
        end else begin
            adv2 = !m_s2 || i_ready;
            free = !m_s1 || adv2;
            g0 = i_valid0 && (!i_valid1 || lg);
            g1 = i_valid1 && (!i_valid0 || !lg);
            a0 = g0 && free;
            a1 = g1 && free;
            chk("rdy0", o_ready0, a0);
            chk("rdy1", o_ready1, a1);
            chk("o_valid", o_valid, m_s2);
            if (m_s2) begin
                if (sb.size() == 0) chk("sb_underrun", 1, 0);
                else begin
                    r = sb[0];
                    chk("o_src", o_src, r.src);
                    chk("o_data", o_data, r.data);
                    chk("o_exp", o_exp, r.exp);
                    chk("o_zero", o_zero, r.zero);
                    chk("o_uf", o_underflow, r.uf);
                    if (i_ready) void'(sb.pop_front());
                end
            end
            if (a0) begin sb.push_back(ref_norm(i_data0, i_exp0, 1'b0)); lg = 0; end
            if (a1) begin sb.push_back(ref_norm(i_data1, i_exp1, 1'b1)); lg = 1; end
            n_s2 = adv2 ? m_s1 : m_s2;
            if (free) m_s1 = a0 || a1;
            m_s2 = n_s2;
        end
    end

    task automatic new_req(input int idx);
        logic [31:0] d;
        logic [7:0]  e;
        d = $urandom;
        d = d >> $urandom_range(32, 8);
        e = $urandom_range(1) ? 8'($urandom_range(255, 0)) : 8'($urandom_range(30, 0));
        if (idx == 0) begin i_valid0 = 1; i_data0 = d[23:0]; i_exp0 = e; end
        else          begin i_valid1 = 1; i_data1 = d[23:0]; i_exp1 = e; end
    endtask

    // One clock: requests hold until accepted, then reissue or drop per gen rate.
    task automatic tick();
        bit a0, a1;
        @(negedge i_clk);
        a0 = i_valid0 && o_ready0;
        a1 = i_valid1 && o_ready1;
        @(posedge i_clk);
        #1;
        if (!i_valid0 || a0) begin
            if (int'($urandom_range(99)) < gen0) new_req(0); else i_valid0 = 0;
        end
        if (!i_valid1 || a1) begin
            if (int'($urandom_range(99)) < gen1) new_req(1); else i_valid1 = 0;
        end
        if (rnd_ready) i_ready = 1'($urandom_range(1));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 0;
        chk("rst_data", o_data, 0);
        chk("rst_exp", o_exp, 0);
        chk("rst_src", o_src, 0);
        chk("rst_zero", o_zero, 0);
        chk("rst_uf", o_underflow, 0);

        // Single request, result two cycles after acceptance.
        i_valid0 = 1; i_data0 = 24'h000100; i_exp0 = 8'd100;
        ticks(2);
        chk("single_valid", o_valid, 1);
        chk("single_data", o_data, 24'h800000);
        chk("single_exp", o_exp, 85);
        chk("single_src", o_src, 0);
        chk("single_flags", {o_zero, o_underflow}, 0);
        ticks(2);

        // Underflow on requester 1.
        i_valid1 = 1; i_data1 = 24'h000001; i_exp1 = 8'd5;
        ticks(2);
        chk("uf_data", o_data, 24'h000020);
        chk("uf_exp", o_exp, 0);
        chk("uf_flag", o_underflow, 1);
        chk("uf_src", o_src, 1);
        ticks(2);

        // Zero mantissa.
        i_valid0 = 1; i_data0 = 24'h0; i_exp0 = 8'd77;
        ticks(2);
        chk("zero_flag", o_zero, 1);
        chk("zero_data", o_data, 0);
        chk("zero_exp", o_exp, 0);
        ticks(2);

        // Continuous tie: alternating grants at full rate.
        gen0 = 100; gen1 = 100;
        new_req(0); new_req(1);
        ticks(10);

        // Backpressure then drain.
        i_ready = 0;
        ticks(5);
        i_ready = 1; gen0 = 0; gen1 = 0;
        ticks(8);

        // Reset with both stages full; first tie afterwards goes to requester 0.
        gen0 = 100; gen1 = 100; i_ready = 0;
        new_req(0); new_req(1);
        ticks(3);
        i_rst = 1;
        tick();
        i_rst = 0; i_ready = 1;
        chk("post_rst_valid", o_valid, 0);
        ticks(6);

        // Random traffic with random backpressure.
        rnd_ready = 1; gen0 = 70; gen1 = 60;
        ticks(400);
        rnd_ready = 0; i_ready = 1; gen0 = 0; gen1 = 0;
        ticks(8);
        chk("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/norm_arbiter.md
NORM_ARBITER -- requirements
Module: norm_arbiter

Interface
REQ-001 The block SHALL have parameter SIZE_DATA, default 24, meaning the mantissa width.
REQ-002 The block SHALL have parameter SIZE_LOPD, default 5, meaning the leading-one position width.
REQ-003 The block SHALL have parameter SIZE_EXP, default 8, meaning the exponent width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port list (name  direction  width  meaning):
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_valid0 / i_valid1  in  1  requester 0/1 has a request.
- o_ready0 / o_ready1  out  1  requester 0/1 request accepted this cycle.
- i_data0 / i_data1  in  SIZE_DATA  unnormalized mantissa.
- i_exp0 / i_exp1  in  SIZE_EXP  biased exponent.
- o_valid  out  1  result valid.
- i_ready  in  1  downstream accepts result.
- o_data  out  SIZE_DATA  normalized mantissa.
- o_exp  out  SIZE_EXP  adjusted exponent.
- o_src  out  1  requester index of result.
- o_zero  out  1  mantissa was all-zero.
- o_underflow  out  1  exponent clamped to 0.

Function
REQ-006 Two-stage pipeline SHALL be implemented: S1 = arbitration/capture register, S2 = normalize/result register; one shared leading-one detector and one left shifter serve both requesters.
REQ-007 Leading-one position SHALL be the bit index counted from LSB (0..SIZE_DATA-1) of the highest set bit of the S1 mantissa; zero flag set when all bits are 0.
REQ-008 Handshakes: transfer on valid&ready; o_valid/data SHALL hold stable until i_ready; a requester may drop i_valid only after transfer.
REQ-009 Advance rules: adv2 = ~o_valid | i_ready; s1_free = ~s1_valid | adv2; S1 content moves to S2 when s1_valid & adv2.
REQ-010 Arbitration SHALL be round-robin with a 1-bit pointer last_grant: only one valid -> grant it; both valid -> grant the requester != last_grant.
REQ-011 o_readyN SHALL equal grantN & s1_free (combinational); never both high in one cycle.
REQ-012 last_grant SHALL update only on an accepted transfer; no update when s1_free=0.
REQ-013 Latency: accepted in cycle N with no stall -> o_valid high in cycle N+2; throughput one result per cycle.
REQ-014 shift = (SIZE_DATA-1) - pos; nonzero mantissa with shift <= exp: o_data = mantissa << shift, o_exp = exp - shift, o_underflow = 0.
REQ-015 Nonzero mantissa with shift > exp: o_data = mantissa << exp, o_exp = 0, o_underflow = 1.
REQ-016 Zero mantissa: o_data = 0, o_exp = 0, o_zero = 1, o_underflow = 0.
REQ-017 o_src SHALL carry the granted index unchanged through both stages.
REQ-018 Simultaneous S2 drain (i_ready) and S1 capture SHALL lose no request; full pipeline with i_ready=0 SHALL drive o_ready0=o_ready1=0.

Reset
REQ-019 On i_rst=1 at a clock edge: s1_valid=0, o_valid=0, last_grant=1 (requester 0 wins first tie), o_data=0, o_exp=0, o_src=0, o_zero=0, o_underflow=0.
REQ-020 Reset mid-operation SHALL discard in-flight S1/S2 content; o_ready0/1 SHALL be 0 while i_rst=1.

Verification
REQ-021 Single request: i_valid0=1, i_data0=0x000100, i_exp0=100, i_ready=1 -> two cycles later o_valid=1, o_data=0x800000, o_exp=85, o_src=0, flags 0.
REQ-022 Tie after reset: both valid every cycle -> grants 0,1,0,1...; results o_src alternate 0,1,0,1 at one per cycle.
REQ-023 Underflow: i_data1=0x000001, i_exp1=5 -> o_data=0x000020, o_exp=0, o_underflow=1, o_src=1.
REQ-024 Zero: i_data0=0, i_exp0=77 -> o_zero=1, o_data=0, o_exp=0.
REQ-025 Backpressure: i_ready=0 for 5 cycles with both requesters valid -> exactly two accepts, then o_ready0=o_ready1=0; o_* stable; release -> in-order drain, no loss or duplicate.
REQ-026 Reset mid-stream: assert i_rst with S1 and S2 full -> next cycle o_valid=0; first tie after release grants requester 0.
